mips_encode_stream: RTL
=======================

// Module: mips_encode_stream
// PURPOSE
//  Inverse of the arithmetic decoder: takes decoded control fields (alu_op, alu_src2, rd_src) plus
//  register numbers and immediate, rebuilds the 32-bit MIPS instruction word, and streams it out.
//  Feeds the instruction-memory loader and the round-trip decode tests. Command combinations the
//  decoder would not produce are rejected and counted. Words leave through a small FIFO.
// PARAMETERS
//  DEPTH      2   output FIFO entries (power of 2, >=2)
//  CNT_WIDTH  16  width of the emitted/rejected counters (saturating)
// PORTS
//  clock        in   1          rising-edge clock
//  reset        in   1          synchronous, active-high
//  in_valid     in   1          command present
//  in_ready     out  1          command accepted when in_valid & in_ready
//  alu_op       in   3          ADD=010 SUB=011 AND=100 OR=101 NOR=110 XOR=111
//  alu_src2     in   2          00 reg, 01 sign-ext imm, 10 zero-ext imm
//  rd_src       in   1          0: dest in rd (R-type); 1: dest in rt (I-type)
//  dst          in   5          destination register
//  src1         in   5          rs
//  src2         in   5          rt source (R-type only; ignored for I-type)
//  imm16        in   16         immediate (I-type only)
//  out_valid    out  1          out_word holds a valid instruction
//  out_ready    in   1          consumer pops when out_valid & out_ready
//  out_word     out  32         encoded instruction (FIFO head)
//  err          out  1          one-cycle pulse: previous accepted command was illegal
//  emit_count   out  CNT_WIDTH  legal words pushed since reset
//  rej_count    out  CNT_WIDTH  illegal commands since reset
// BEHAVIOUR
//  Legal set (all others illegal):
//   R: rd_src=0, alu_src2=00, alu_op in {ADD,SUB,AND,OR,NOR,XOR} ->
//      {6'h00, src1, src2, dst, 5'b0, funct}, funct ADD 20 SUB 22 AND 24 OR 25 XOR 26 NOR 27 (hex)
//   I: rd_src=1 with (ADD,01)->op 08, (AND,10)->0c, (OR,10)->0d, (XOR,10)->0e ->
//      {op, src1, dst, imm16}; imm16 copied unchanged (extension is the decoder's job)
//  Encoding is combinational on the inputs; FIFO push is registered.
//  in_ready = (fill < DEPTH); it does not depend on out_ready or on legality.
//  Accepted legal: word written at the tail; out_valid is high from the next cycle (latency 1).
//  Accepted illegal: nothing pushed; err=1 for exactly the next cycle; rej_count+1.
//  Push and pop in the same cycle: fill unchanged and order preserved.
//   fill=0 cannot pop; in_ready=0 when full, so no push at fill=DEPTH.
//  Pointers wrap modulo DEPTH; strict FIFO order; out_word stable while out_valid & !out_ready.
//  Counters saturate at all-ones and do not wrap.
//  Reset (also mid-stream): fill=0, pointers=0, out_valid=0, out_word=0, err=0, both counters=0.
//   Queued words are discarded. in_ready=0 during the reset cycle and 1 after it.
//  out_word is 0 whenever out_valid=0.
// TESTING
//  1 R ADD dst=3 src1=1 src2=2, out_ready=1 -> next cycle out_word=32'h00221820, out_valid=1, emit_count=1
//  2 I ADD(01) dst=5 src1=4 imm=16'hFFFF -> 32'h2085FFFF; XOR(10) dst=2 src1=2 imm=16'h00F0 -> 32'h384200F0
//  3 Illegal: rd_src=0, alu_src2=10, op=AND -> no out_valid, err pulses 1 cycle, rej_count=1;
//    also SUB with src2=01 -> rejected
//  4 out_ready=0, issue 3 legal cmds -> in_ready falls after 2 accepts; raise out_ready ->
//    words drain in issue order, in_ready returns the next cycle
//  5 Simultaneous push/pop at fill=1 for 10 cycles -> fill stays 1, no loss or duplication,
//    pointer wrap covered
//  6 reset asserted with fill=2 -> next cycle out_valid=0, counters=0; a new command then encodes normally

Source files
------------

// File: rtl/mips_encode_stream.sv
// mips_encode_stream: rebuilds MIPS instruction words from decoded control fields and streams them out through a small FIFO
// Ports: clock/reset (sync, active-high); in_valid/in_ready command handshake carrying alu_op, alu_src2,
// rd_src, dst, src1, src2, imm16; out_valid/out_ready/out_word FIFO head; err pulses after an illegal
// accepted command; emit_count/rej_count are saturating counts of pushed words and rejected commands.
module mips_encode_stream #(
  parameter int DEPTH = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           alu_op,
  input  logic [1:0]           alu_src2,
  input  logic                 rd_src,
  input  logic [4:0]           dst,
  input  logic [4:0]           src1,
  input  logic [4:0]           src2,
  input  logic [15:0]          imm16,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_word,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] emit_count,
  output logic [CNT_WIDTH-1:0] rej_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] fill;
  logic [5:0] funct, opc;
  logic legal, acc, push, pop;
  logic [31:0] word;
  always_comb begin
    funct = alu_op == 3'b010 ? 6'h20 : alu_op == 3'b011 ? 6'h22 : alu_op == 3'b100 ? 6'h24 :
            alu_op == 3'b101 ? 6'h25 : alu_op == 3'b110 ? 6'h27 : 6'h26;
    opc = alu_op == 3'b010 ? 6'h08 : alu_op == 3'b100 ? 6'h0c : alu_op == 3'b101 ? 6'h0d : 6'h0e;
    legal = rd_src ? (alu_op == 3'b010 ? alu_src2 == 2'b01 : alu_src2 == 2'b10 && alu_op[2] && alu_op != 3'b110)
                   : alu_src2 == 2'b00 && alu_op[2:1] != 2'b00;
    word = rd_src ? {opc, src1, dst, imm16} : {6'h00, src1, src2, dst, 5'b0, funct};
  end
  assign in_ready = !reset && fill != FULL;
  assign acc = in_valid && in_ready;
  assign push = acc && legal;
  assign out_valid = fill != '0;
  assign pop = out_valid && out_ready;
  assign out_word = out_valid ? mem[rp] : 32'h0;
  always_ff @(posedge clock)
    if (push) mem[wp] <= word;
  always_ff @(posedge clock) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      fill <= '0;
      err <= 1'b0;
      emit_count <= '0;
      rej_count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      fill <= fill + (AW+1)'(push) - (AW+1)'(pop);
      err <= acc && !legal;
      if (push && ~&emit_count) emit_count <= emit_count + 1'b1;
      if (acc && !legal && ~&rej_count) rej_count <= rej_count + 1'b1;
    end
  end
endmodule
